// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the sequential post-add normalizer.
package fp_norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_e;

  localparam int EXP_MIN_NORMAL = 1;

  // All-ones biased exponent (Inf/NaN encoding) for a given exponent width.
  function automatic int exp_max_of(input int e);
    return (1 << e) - 1;
  endfunction

endpackage

// File: rtl/fp_normalize_seq.sv
// Post-add normalizer: right-shift on carry, iterative one-bit-per-cycle left
// shift otherwise, with zero / underflow / overflow classification.
module fp_normalize_seq
  import fp_norm_pkg::*;
#(
  parameter int N = 24,
  parameter int E = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] mant_in,
  input  logic         c_out_in,
  input  logic [E-1:0] exp_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] mant_out,
  output logic [E-1:0] exp_out,
  output logic         guard_out,
  output logic         zero_out,
  output logic         underflow_out,
  output logic         overflow_out
);

  localparam logic [E-1:0] EXP_MAX = E'(exp_max_of(E));
  localparam logic [E-1:0] EXP_OVF = EXP_MAX - 1'b1;
  localparam logic [E-1:0] EXP_ONE = E'(EXP_MIN_NORMAL);

  norm_state_e  state, state_n;
  logic [N-1:0] mant_q, mant_d;
  logic [E-1:0] exp_q, exp_d;
  logic         guard_q, guard_d;
  logic         zero_q, zero_d;
  logic         unf_q, unf_d;
  logic         ovf_q, ovf_d;
  logic         vld_q, vld_d;

  assign in_ready = (state == IDLE) && !rst;

  always_comb begin
    state_n = state;
    mant_d  = mant_q;
    exp_d   = exp_q;
    guard_d = guard_q;
    zero_d  = zero_q;
    unf_d   = unf_q;
    ovf_d   = ovf_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          mant_d  = mant_in;
          exp_d   = exp_in;
          guard_d = 1'b0;
          zero_d  = 1'b0;
          unf_d   = 1'b0;
          ovf_d   = 1'b0;
          state_n = DONE;
          if (exp_in == EXP_MAX) begin
            // Inf/NaN operand: pass through untouched
          end else if (c_out_in) begin
            mant_d  = {1'b1, mant_in[N-1:1]};
            guard_d = mant_in[0];
            if (exp_in == EXP_OVF) begin
              exp_d  = EXP_MAX;
              mant_d = '0;
              ovf_d  = 1'b1;
            end else begin
              exp_d = exp_in + 1'b1;
            end
          end else if (mant_in == '0) begin
            exp_d  = '0;
            zero_d = 1'b1;
          end else if (mant_in[N-1] || exp_in == '0) begin
            // already normalized, or denormal input stays denormal
          end else begin
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (mant_q[N-1]) begin
          state_n = DONE;
        end else if (exp_q == EXP_ONE) begin
          // Ran out of exponent range: leave the mantissa as a denormal
          exp_d   = '0;
          unf_d   = 1'b1;
          state_n = DONE;
        end else begin
          mant_d = {mant_q[N-2:0], 1'b0};
          exp_d  = exp_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    vld_d = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      guard_q <= 1'b0;
      zero_q  <= 1'b0;
      unf_q   <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state   <= state_n;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      guard_q <= guard_d;
      zero_q  <= zero_d;
      unf_q   <= unf_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign out_valid     = vld_q;
  assign mant_out      = mant_q;
  assign exp_out       = exp_q;
  assign guard_out     = guard_q;
  assign zero_out      = zero_q;
  assign underflow_out = unf_q;
  assign overflow_out  = ovf_q;

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Randomized self-checking bench for fp_normalize_seq against a behavioural model.
module tb_fp_normalize_seq;
  localparam int N = 24;
  localparam int E = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] mant_in;
  logic         c_out_in;
  logic [E-1:0] exp_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] mant_out;
  logic [E-1:0] exp_out;
  logic         guard_out, zero_out, underflow_out, overflow_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_normalize_seq #(.N(N), .E(E)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mant_in(mant_in), .c_out_in(c_out_in), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready), .mant_out(mant_out),
    .exp_out(exp_out), .guard_out(guard_out), .zero_out(zero_out),
    .underflow_out(underflow_out), .overflow_out(overflow_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: leading-zero count done arithmetically, clipped by exponent range.
  function automatic void model(input logic [N-1:0] m, input logic c, input logic [E-1:0] e,
                                output logic [N-1:0] mo, output logic [E-1:0] eo,
                                output logic g, output logic z, output logic u,
                                output logic o, output int lat);
    int ev;
    int lz;
    ev = int'(e);
    mo = m; eo = e; g = 0; z = 0; u = 0; o = 0; lat = 1;
    if (ev == (1 << E) - 1) begin
    end else if (c) begin
      mo = {1'b1, m[N-1:1]};
      g  = m[0];
      if (ev == (1 << E) - 2) begin
        eo = E'((1 << E) - 1);
        mo = '0;
        o  = 1;
      end else begin
        eo = E'(ev + 1);
      end
    end else if (m == '0) begin
      mo = '0; eo = '0; z = 1;
    end else if (m[N-1] || ev == 0) begin
    end else begin
      lz = 0;
      while (!m[N-1-lz]) lz++;
      if (ev > lz) begin
        mo = m << lz; eo = E'(ev - lz); lat = 2 + lz;
      end else begin
        mo = m << (ev - 1); eo = '0; u = 1; lat = 2 + ev - 1;
      end
    end
  endfunction

  task automatic run(input logic [N-1:0] m, input logic c, input logic [E-1:0] e,
                     input int hold, input string tag);
    logic [N-1:0] xm;
    logic [E-1:0] xe;
    logic xg, xz, xu, xo;
    int xlat, lat, w;
    model(m, c, e, xm, xe, xg, xz, xu, xo, xlat);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1; mant_in = m; c_out_in = c; exp_in = e;
    @(posedge clk);
    #1;
    in_valid = 0; mant_in = N'($urandom); c_out_in = 1'($urandom); exp_in = E'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, 64'(lat), 64'(xlat));
    chk({tag, "_mant"}, 64'(mant_out), 64'(xm));
    chk({tag, "_exp"}, 64'(exp_out), 64'(xe));
    chk({tag, "_flags"}, 64'({guard_out, zero_out, underflow_out, overflow_out}),
        64'({xg, xz, xu, xo}));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1;
      @(negedge clk);
      chk({tag, "_hold"}, 64'({out_valid, in_ready, mant_out, exp_out,
          guard_out, zero_out, underflow_out, overflow_out}),
          64'({1'b1, 1'b0, xm, xe, xg, xz, xu, xo}));
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_drain"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
  endtask

  initial begin
    logic [N-1:0] m;
    logic [E-1:0] e;
    logic c;
    int sel;
    rst = 1; in_valid = 0; out_ready = 0; mant_in = '0; c_out_in = 0; exp_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_out", 64'({out_valid, in_ready, mant_out, exp_out, guard_out,
        zero_out, underflow_out, overflow_out}), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("reset_rdy", 64'(in_ready), 64'd1);

    run(24'h400000, 0, 8'd130, 0, "norm1");
    run(24'h000003, 1, 8'd127, 0, "carry");
    run(24'h000000, 0, 8'd100, 0, "zero");
    run(24'h000001, 0, 8'd5,   0, "unf");
    run(24'hFFFFFF, 1, 8'd254, 0, "ovf");
    run(24'h123456, 1, 8'd255, 0, "inf");
    run(24'h012345, 0, 8'd0,   0, "denorm");
    run(24'h000001, 0, 8'd200, 0, "maxshift");
    run(24'h400000, 0, 8'd1,   0, "exp1");
    run(24'h0ABCDE, 0, 8'd60,  3, "bp");

    // Reset while shifting discards the operand
    @(negedge clk);
    in_valid = 1; mant_in = 24'h000100; c_out_in = 0; exp_in = 8'd100;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_shift", 64'({out_valid, in_ready, mant_out, exp_out, guard_out,
        zero_out, underflow_out, overflow_out}), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("rst_rdy", 64'(in_ready), 64'd1);

    for (int t = 0; t < 150; t++) begin
      m = N'($urandom) >> $urandom_range(0, N);
      c = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0: e = 8'd254;
        1: e = 8'd255;
        2: e = 8'd0;
        3: e = E'($urandom_range(1, 6));
        default: e = E'($urandom_range(1, 253));
      endcase
      run(m, c, e, $urandom_range(0, 2), $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
